// File: rtl/fifo_pkg.sv
// Shared types for the FWFT status FIFO: overflow handling mode.
package fifo_pkg;

  typedef enum logic {
    FIFO_BLOCK     = 1'b0,
    FIFO_OVERWRITE = 1'b1
  } fifo_mode_e;

endpackage

// File: rtl/fifo_ram.sv
// DATA_WIDTH x DEPTH register array: synchronous write port, combinational read port.
module fifo_ram #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_en) begin
      mem_r[w_addr] <= w_data;
    end
  end

  assign r_data = mem_r[r_addr];

endmodule

// File: rtl/fifo_fwft_status.sv
// First-word-fall-through FIFO with occupancy count, threshold flags, sticky
// overflow/underflow and optional drop-oldest overwrite mode.
module fifo_fwft_status
  import fifo_pkg::*;
#(
  parameter int         DATA_WIDTH = 24,
  parameter int         ADDR_WIDTH = 3,
  parameter int         AF_THRESH  = 6,
  parameter int         AE_THRESH  = 2,
  parameter fifo_mode_e MODE       = FIFO_BLOCK
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_CNT    = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_CNT    = AE_THRESH[ADDR_WIDTH:0];

  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_af_range
    $fatal(1, "fifo_fwft_status: AF_THRESH must lie in 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_ae_range
    $fatal(1, "fifo_fwft_status: AE_THRESH must lie in 0..DEPTH-1");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_r, rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r, count_nxt_s;
  logic                  overflow_r, underflow_r;
  logic                  empty_s, full_s;
  logic                  rd_ok_s, wr_ok_s, drop_s, ovf_evt_s, udf_evt_s;
  logic [DATA_WIDTH-1:0] ram_data_s;

  assign empty_s = (count_r == {(ADDR_WIDTH+1){1'b0}});
  assign full_s  = (count_r == DEPTH_CNT);

  // Accept/reject decisions and next occupancy; a drop moves both pointers so count holds.
  always_comb begin
    rd_ok_s     = rd & ~empty_s;
    ovf_evt_s   = wr & full_s & ~rd_ok_s;
    udf_evt_s   = rd & empty_s;
    wr_ok_s     = 1'b0;
    drop_s      = 1'b0;
    count_nxt_s = count_r;
    case (MODE)
      FIFO_OVERWRITE: begin
        wr_ok_s = wr;
        drop_s  = ovf_evt_s;
      end
      FIFO_BLOCK: begin
        wr_ok_s = wr & ~ovf_evt_s;
        drop_s  = 1'b0;
      end
      default: begin
        wr_ok_s = 1'b0;
        drop_s  = 1'b0;
      end
    endcase
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_nxt_s = drop_s ? count_r : count_r + (ADDR_WIDTH+1)'(1'b1);
      2'b01:   count_nxt_s = count_r - (ADDR_WIDTH+1)'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy and sticky error flags; an error event beats clear_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r    <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r    <= {ADDR_WIDTH{1'b0}};
      count_r     <= {(ADDR_WIDTH+1){1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1'b1);
      end
      if (rd_ok_s | drop_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1'b1);
      end
      count_r     <= count_nxt_s;
      overflow_r  <= ovf_evt_s | (overflow_r & ~clear_err);
      underflow_r <= udf_evt_s | (underflow_r & ~clear_err);
    end
  end

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .w_en  (wr_ok_s),
    .w_addr(wr_ptr_r),
    .w_data(w_data),
    .r_addr(rd_ptr_r),
    .r_data(ram_data_s)
  );

  assign r_data       = empty_s ? {DATA_WIDTH{1'b0}} : ram_data_s;
  assign empty        = empty_s;
  assign full         = full_s;
  assign almost_empty = (count_r <= AE_CNT);
  assign almost_full  = (count_r >= AF_CNT);
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_fwft_status.sv
// Drives a blocking and an overwrite FIFO with shared stimulus and checks both
// against queue-based models every cycle, plus hand-computed expectations.
module tb_fifo_fwft_status;
  import fifo_pkg::*;

  localparam int DW = 24, AW = 3, DEPTH = 8, AF = 6, AE = 2;

  logic clk, reset, rd, wr, clear_err;
  logic [DW-1:0] w_data;

  logic [DW-1:0] r_data_a, r_data_b;
  logic empty_a, full_a, ae_a, af_a, ovf_a, udf_a;
  logic empty_b, full_b, ae_b, af_b, ovf_b, udf_b;
  logic [AW:0] count_a, count_b;

  int checks = 0;
  int failures = 0;

  fifo_fwft_status #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE),
                     .MODE(FIFO_BLOCK)) u_blk (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .w_data(w_data), .clear_err(clear_err),
    .r_data(r_data_a), .empty(empty_a), .full(full_a), .almost_empty(ae_a),
    .almost_full(af_a), .count(count_a), .overflow(ovf_a), .underflow(udf_a));

  fifo_fwft_status #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE),
                     .MODE(FIFO_OVERWRITE)) u_ovw (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .w_data(w_data), .clear_err(clear_err),
    .r_data(r_data_b), .empty(empty_b), .full(full_b), .almost_empty(ae_b),
    .almost_full(af_b), .count(count_b), .overflow(ovf_b), .underflow(udf_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queues holding the FIFO contents, oldest first.
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  bit m_ovf_a, m_udf_a, m_ovf_b, m_udf_b;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      qa.delete();
      qb.delete();
      m_ovf_a <= 1'b0; m_udf_a <= 1'b0;
      m_ovf_b <= 1'b0; m_udf_b <= 1'b0;
    end else begin
      m_ovf_a <= (wr && qa.size() == DEPTH && !rd) ? 1'b1 : (clear_err ? 1'b0 : m_ovf_a);
      m_udf_a <= (rd && qa.size() == 0) ? 1'b1 : (clear_err ? 1'b0 : m_udf_a);
      m_ovf_b <= (wr && qb.size() == DEPTH && !rd) ? 1'b1 : (clear_err ? 1'b0 : m_ovf_b);
      m_udf_b <= (rd && qb.size() == 0) ? 1'b1 : (clear_err ? 1'b0 : m_udf_b);
      if (!(wr && qa.size() == DEPTH && !rd)) begin
        if (rd && qa.size() != 0) void'(qa.pop_front());
        if (wr) qa.push_back(w_data);
      end
      if (wr && qb.size() == DEPTH && !rd) begin
        void'(qb.pop_front());
        qb.push_back(w_data);
      end else begin
        if (rd && qb.size() != 0) void'(qb.pop_front());
        if (wr) qb.push_back(w_data);
      end
    end
  end

  task automatic check_dut(input string tag, input logic [AW:0] cnt, input logic e, input logic f,
                           input logic ae, input logic af, input logic [DW-1:0] rdat,
                           input logic ov, input logic un, input int n,
                           input logic [DW-1:0] head, input bit eov, input bit eun);
    chk({tag, ".count"}, 32'(cnt), 32'(n));
    chk({tag, ".empty"}, 32'(e), 32'(n == 0));
    chk({tag, ".full"}, 32'(f), 32'(n == DEPTH));
    chk({tag, ".almost_empty"}, 32'(ae), 32'(n <= AE));
    chk({tag, ".almost_full"}, 32'(af), 32'(n >= AF));
    chk({tag, ".r_data"}, 32'(rdat), (n == 0) ? 32'h0 : 32'(head));
    chk({tag, ".overflow"}, 32'(ov), 32'(eov));
    chk({tag, ".underflow"}, 32'(un), 32'(eun));
  endtask

  // Every falling edge: DUT outputs must match the model state.
  always @(negedge clk) begin
    check_dut("blk", count_a, empty_a, full_a, ae_a, af_a, r_data_a, ovf_a, udf_a,
              qa.size(), (qa.size() != 0) ? qa[0] : 24'h0, m_ovf_a, m_udf_a);
    check_dut("ovw", count_b, empty_b, full_b, ae_b, af_b, r_data_b, ovf_b, udf_b,
              qb.size(), (qb.size() != 0) ? qb[0] : 24'h0, m_ovf_b, m_udf_b);
  end

  task automatic step(input bit r, input bit w, input logic [DW-1:0] d, input bit c);
    rd = r; wr = w; w_data = d; clear_err = c;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0; clear_err = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".rst_count_a"}, 32'(count_a), 32'h0);
    chk({tag, ".rst_empty_a"}, 32'(empty_a), 32'h1);
    chk({tag, ".rst_full_a"}, 32'(full_a), 32'h0);
    chk({tag, ".rst_ae_a"}, 32'(ae_a), 32'h1);
    chk({tag, ".rst_af_a"}, 32'(af_a), 32'h0);
    chk({tag, ".rst_ovf_a"}, 32'(ovf_a), 32'h0);
    chk({tag, ".rst_udf_a"}, 32'(udf_a), 32'h0);
    chk({tag, ".rst_rdata_a"}, 32'(r_data_a), 32'h0);
    chk({tag, ".rst_count_b"}, 32'(count_b), 32'h0);
    chk({tag, ".rst_empty_b"}, 32'(empty_b), 32'h1);
    chk({tag, ".rst_ovf_b"}, 32'(ovf_b), 32'h0);
    chk({tag, ".rst_rdata_b"}, 32'(r_data_b), 32'h0);
  endtask

  initial begin
    reset = 1'b0; rd = 1'b0; wr = 1'b0; w_data = 24'h0; clear_err = 1'b0;
    #1;
    check_reset_values("init");
    #11 reset = 1'b1;
    @(negedge clk);

    // Basic ordering and almost_empty edge
    step(1'b0, 1'b1, 24'h000001, 1'b0);
    step(1'b0, 1'b1, 24'h000002, 1'b0);
    chk("ae_after_2", 32'(ae_a), 32'h1);
    step(1'b0, 1'b1, 24'h000003, 1'b0);
    chk("ae_after_3", 32'(ae_a), 32'h0);
    chk("count_3", 32'(count_a), 32'h3);
    for (int i = 1; i <= 3; i++) begin
      chk("head_order", 32'(r_data_a), 32'(i));
      step(1'b1, 1'b0, 24'h0, 1'b0);
    end
    chk("drained_empty", 32'(empty_a), 32'h1);
    chk("drained_rdata", 32'(r_data_a), 32'h0);

    // Overfill with 0xA0..0xA8
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 24'(32'hA0 + i), 1'b0);
    chk("blk_full", 32'(full_a), 32'h1);
    chk("blk_af", 32'(af_a), 32'h1);
    chk("blk_ovf", 32'(ovf_a), 32'h1);
    chk("ovw_head_a1", 32'(r_data_b), 32'hA1);
    for (int i = 0; i < 8; i++) begin
      chk("blk_drain", 32'(r_data_a), 32'hA0 + 32'(i));
      step(1'b1, 1'b0, 24'h0, 1'b0);
    end
    step(1'b0, 1'b0, 24'h0, 1'b1);
    chk("ovf_cleared", 32'(ovf_a), 32'h0);

    // Overwrite with 0xB0..0xB9
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 24'(32'hB0 + i), 1'b0);
    chk("ovw_count", 32'(count_b), 32'h8);
    chk("ovw_ovf", 32'(ovf_b), 32'h1);
    for (int i = 0; i < 8; i++) begin
      chk("ovw_drain", 32'(r_data_b), 32'hB2 + 32'(i));
      step(1'b1, 1'b0, 24'h0, 1'b0);
    end
    step(1'b0, 1'b0, 24'h0, 1'b1);

    // Simultaneous rd & wr when full, then when empty
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 24'(32'hC0 + i), 1'b0);
    step(1'b1, 1'b1, 24'h0000CC, 1'b0);
    chk("rw_full_count", 32'(count_a), 32'h8);
    chk("rw_full_ovf", 32'(ovf_a), 32'h0);
    chk("rw_full_ovf_b", 32'(ovf_b), 32'h0);
    chk("rw_full_head", 32'(r_data_a), 32'hC1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 24'h0, 1'b0);
    step(1'b1, 1'b1, 24'h123456, 1'b0);
    chk("rw_empty_count", 32'(count_a), 32'h1);
    chk("rw_empty_rdata", 32'(r_data_a), 32'h123456);
    chk("rw_empty_udf", 32'(udf_a), 32'h1);

    // Sticky flags versus clear_err
    step(1'b0, 1'b0, 24'h0, 1'b1);
    step(1'b1, 1'b0, 24'h0, 1'b0);
    step(1'b1, 1'b0, 24'h0, 1'b0);
    chk("udf_set", 32'(udf_a), 32'h1);
    step(1'b0, 1'b0, 24'h0, 1'b1);
    chk("udf_cleared", 32'(udf_a), 32'h0);
    step(1'b1, 1'b0, 24'h0, 1'b1);
    chk("udf_set_wins", 32'(udf_a), 32'h1);
    step(1'b0, 1'b0, 24'h0, 1'b1);

    // Pointer wrap with steady occupancy of three
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 24'(32'hD0 + i), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 24'($urandom), 1'b0);
    chk("wrap_count", 32'(count_a), 32'h3);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 24'h0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 55, 24'($urandom),
           $urandom_range(0, 15) == 0);

    // Reset in the middle of operation, away from any clock edge
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 24'h0, 1'b0);
    step(1'b0, 1'b0, 24'h0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 24'(32'hE0 + i), 1'b0);
    chk("pre_reset_count", 32'(count_a), 32'h5);
    #2 reset = 1'b0;
    #1 check_reset_values("mid");
    #1 reset = 1'b1;
    @(negedge clk);
    step(1'b0, 1'b1, 24'h000777, 1'b0);
    chk("post_reset_head", 32'(r_data_a), 32'h777);
    chk("post_reset_count", 32'(count_a), 32'h1);
    step(1'b0, 1'b0, 24'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_fwft_status.md
# fifo_fwft_status

Parametrised first-word-fall-through FIFO for the audio datapath: occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable overwrite mode that drops the oldest sample instead of stalling. It sits between the codec sample interface and downstream filter stages, so bursts on either side never corrupt the stream silently.

## Interface
- DATA_WIDTH, 24, sample width in bits
- ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH
- AF_THRESH, 6, almost_full asserted when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
- MODE, FIFO_BLOCK, fifo_pkg::fifo_mode_e; FIFO_BLOCK rejects writes when full, FIFO_OVERWRITE drops the oldest entry
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- rd  in  1  pop head (head is already on r_data)
- wr  in  1  push w_data
- w_data  in  DATA_WIDTH  write data
- clear_err  in  1  synchronous clear of overflow/underflow
- r_data  out  DATA_WIDTH  head entry; forced to 0 while empty
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count <= AE_THRESH
- almost_full  out  1  count >= AF_THRESH
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected or an entry dropped
- underflow  out  1  sticky: rd while empty

## Operation
- Reset, asserted asynchronously: pointers = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0, r_data = 0. Storage is not reset.
- rd_ok = rd & ~empty. rd while empty is ignored, and underflow is set.
- FIFO_BLOCK: wr_ok = wr & (~full | rd_ok). wr while full without rd_ok is dropped, and overflow is set.
- FIFO_OVERWRITE: wr while full without rd advances both pointers. The new word is written at the tail, the old head is lost, count stays DEPTH, and overflow is set.
- wr & rd while full, either mode: the pop and push both occur, count is unchanged, no error.
- wr & rd while empty: the write occurs, the read is ignored, and underflow is set. Count becomes 1.
- Pointers are ADDR_WIDTH wide and wrap naturally at DEPTH; there is no explicit modulo.
- count updates by +1 on write only, -1 on read only, and 0 when both occur or on an overwrite-drop.
- All status flags decode combinationally from the registered count.
- clear_err clears both sticky flags. If an error event occurs in the same cycle as clear_err, the set wins.
- Thresholds are checked at elaboration. A violation of the ranges above is a $fatal.

## Timing
- Write on edge k: the word is visible on r_data, with empty low, from edge k (cycle k+1) if the FIFO was empty. Write-to-read latency is 1 cycle.
- rd on edge k: the next head appears on r_data after edge k. r_data is a combinational read of storage at the head pointer, masked by empty.
- count and all flags are valid one edge after the causing rd/wr. They never glitch on reset release.
- Reset mid-operation: all contents are discarded immediately. The first write after reset release lands at address 0.
- No combinational path exists from rd/wr to any output.

## Structure
- fifo_pkg: typedef enum logic {FIFO_BLOCK, FIFO_OVERWRITE} fifo_mode_e.
- One sub-module, fifo_ram: a parametrised DATA_WIDTH × DEPTH register array with a synchronous write port (w_en, w_addr, w_data) and a combinational read port (r_addr, r_data).
- The top level holds the pointers, count, error flags and flag decode.

## Test plan
All scenarios use DATA_WIDTH=24, ADDR_WIDTH=3, AF_THRESH=6, AE_THRESH=2.
- Reset, then write 0x000001..0x000003: count=3, almost_empty drops after the 3rd write, r_data=0x000001. Three rds return 1, 2, 3 in order, then empty=1 and r_data=0.
- FIFO_BLOCK: write 9 words 0xA0..0xA8. full=1 and almost_full=1 after the 8th, the 9th is rejected, and overflow=1. Draining returns 0xA0..0xA7.
- FIFO_OVERWRITE: write 0xB0..0xB9 (10 words). count=8, overflow=1, and draining returns 0xB2..0xB9.
- Simultaneous rd & wr: when full, count stays 8 and no error occurs. When empty with w_data=0x123456, count=1, r_data=0x123456, and underflow=1.
- Sticky flags: create an underflow, then hold clear_err for 1 cycle so the flags clear. Repeat with rd while empty in the same cycle as clear_err; underflow stays 1.
- Wrap-around and reset: run 20 push/pop pairs with 3-deep occupancy and confirm ordering across the pointer wrap. Then assert reset while count=5; all outputs return to reset values with no clock edge needed.
